// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter sharing one 32-bit peripheral port.
// An ID FIFO records which master issued each outstanding read so in-order responses are routed back.
module periph_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_byte_enable,
  input  logic        m0_write_req,
  input  logic        m0_read_req,
  output logic        m0_ready,
  output logic [31:0] m0_read_data,
  output logic        m0_read_data_valid,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_byte_enable,
  input  logic        m1_write_req,
  input  logic        m1_read_req,
  output logic        m1_ready,
  output logic [31:0] m1_read_data,
  output logic        m1_read_data_valid,
  output logic [31:0] s_write_data,
  output logic [3:0]  s_byte_enable,
  output logic        s_write_req,
  output logic        s_read_req,
  input  logic [31:0] s_read_data,
  input  logic        s_read_data_valid
);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PTR_W:0] DEPTH = MAX_OUTSTANDING[PTR_W:0];

  logic [MAX_OUTSTANDING-1:0] id_mem;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W:0]             count;
  logic                       last_grant;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       head_id;
  logic                       elig0;
  logic                       elig1;
  logic                       grant0;
  logic                       grant1;
  logic                       push;
  logic                       pop;

  assign fifo_full  = (count == DEPTH);
  assign fifo_empty = (count == '0);
  assign head_id    = id_mem[rd_ptr];

  // Reads are held off on the registered full flag; writes always pass.
  assign elig0 = reset_n & (m0_write_req | m0_read_req) & ~(m0_read_req & fifo_full);
  assign elig1 = reset_n & (m1_write_req | m1_read_req) & ~(m1_read_req & fifo_full);

  // On a tie the master that did not win last time is granted.
  assign grant0 = elig0 & (~elig1 | last_grant);
  assign grant1 = elig1 & (~elig0 | ~last_grant);

  assign m0_ready = grant0;
  assign m1_ready = grant1;

  assign s_write_req   = (grant0 & m0_write_req) | (grant1 & m1_write_req);
  assign s_read_req    = (grant0 & m0_read_req)  | (grant1 & m1_read_req);
  assign s_write_data  = grant1 ? m1_write_data  : m0_write_data;
  assign s_byte_enable = grant1 ? m1_byte_enable : m0_byte_enable;

  assign push = s_read_req;
  assign pop  = s_read_data_valid & ~fifo_empty;

  assign m0_read_data       = s_read_data;
  assign m1_read_data       = s_read_data;
  assign m0_read_data_valid = pop & (head_id == 1'b0);
  assign m1_read_data_valid = pop & (head_id == 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
    end else begin
      if (grant0 | grant1) last_grant <= grant1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= grant1;
  end
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: grants, round-robin, read routing, FIFO full/wrap and reset.
module tb_periph_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] m0_write_data, m1_write_data, s_write_data, s_read_data;
  logic [3:0]  m0_byte_enable, m1_byte_enable, s_byte_enable;
  logic        m0_write_req, m0_read_req, m1_write_req, m1_read_req;
  logic        m0_ready, m1_ready, m0_read_data_valid, m1_read_data_valid;
  logic [31:0] m0_read_data, m1_read_data;
  logic        s_write_req, s_read_req, s_read_data_valid;

  int checks = 0;
  int passes = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  periph_bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_write_data(m0_write_data), .m0_byte_enable(m0_byte_enable),
    .m0_write_req(m0_write_req), .m0_read_req(m0_read_req), .m0_ready(m0_ready),
    .m0_read_data(m0_read_data), .m0_read_data_valid(m0_read_data_valid),
    .m1_write_data(m1_write_data), .m1_byte_enable(m1_byte_enable),
    .m1_write_req(m1_write_req), .m1_read_req(m1_read_req), .m1_ready(m1_ready),
    .m1_read_data(m1_read_data), .m1_read_data_valid(m1_read_data_valid),
    .s_write_data(s_write_data), .s_byte_enable(s_byte_enable),
    .s_write_req(s_write_req), .s_read_req(s_read_req),
    .s_read_data(s_read_data), .s_read_data_valid(s_read_data_valid)
  );

  task automatic idle();
    m0_write_data = '0; m0_byte_enable = '0; m0_write_req = 1'b0; m0_read_req = 1'b0;
    m1_write_data = '0; m1_byte_enable = '0; m1_write_req = 1'b0; m1_read_req = 1'b0;
    s_read_data = '0; s_read_data_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle();
    m0_write_req = 1'b1; m1_read_req = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (m0_ready !== 1'b0) $display("FAIL reset_m0_ready got %b want 0", m0_ready); else passes++;
    checks++; if (m1_ready !== 1'b0) $display("FAIL reset_m1_ready got %b want 0", m1_ready); else passes++;
    checks++; if ({s_write_req, s_read_req} !== 2'b00) $display("FAIL reset_s_req got %b want 00", {s_write_req, s_read_req}); else passes++;
    checks++; if (dut.count !== 3'd0) $display("FAIL reset_count got %0d want 0", dut.count); else passes++;
    checks++; if (dut.last_grant !== 1'b1) $display("FAIL reset_last_grant got %b want 1", dut.last_grant); else passes++;
    checks++; if ({m0_read_data_valid, m1_read_data_valid} !== 2'b00) $display("FAIL reset_valid got %b want 00", {m0_read_data_valid, m1_read_data_valid}); else passes++;
    idle();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    m0_write_req = 1'b1; m0_write_data = 32'h5; m0_byte_enable = 4'h1;
    @(negedge clk);
    checks++; if (m0_ready !== 1'b1) $display("FAIL sw_m0_ready got %b want 1", m0_ready); else passes++;
    checks++; if (m1_ready !== 1'b0) $display("FAIL sw_m1_ready got %b want 0", m1_ready); else passes++;
    checks++; if (s_write_req !== 1'b1) $display("FAIL sw_s_write_req got %b want 1", s_write_req); else passes++;
    checks++; if (s_read_req !== 1'b0) $display("FAIL sw_s_read_req got %b want 0", s_read_req); else passes++;
    checks++; if (s_write_data !== 32'h5) $display("FAIL sw_s_write_data got %h want 5", s_write_data); else passes++;
    checks++; if (s_byte_enable !== 4'h1) $display("FAIL sw_s_byte_enable got %h want 1", s_byte_enable); else passes++;
    step();
    checks++; if (dut.last_grant !== 1'b0) $display("FAIL sw_last_grant got %b want 0", dut.last_grant); else passes++;
    idle();
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_write_req = 1'b1; m0_write_data = 32'hA0A0_0000; m0_byte_enable = 4'hF;
    m1_write_req = 1'b1; m1_write_data = 32'hB1B1_0000; m1_byte_enable = 4'h3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        checks++; if ({m1_ready, m0_ready} !== 2'b01) $display("FAIL rr_grant cyc %0d got %b want 01", i, {m1_ready, m0_ready}); else passes++;
        checks++; if (s_write_data !== 32'hA0A0_0000) $display("FAIL rr_data cyc %0d got %h want a0a00000", i, s_write_data); else passes++;
      end else begin
        checks++; if ({m1_ready, m0_ready} !== 2'b10) $display("FAIL rr_grant cyc %0d got %b want 10", i, {m1_ready, m0_ready}); else passes++;
        checks++; if (s_byte_enable !== 4'h3) $display("FAIL rr_be cyc %0d got %h want 3", i, s_byte_enable); else passes++;
      end
      step();
    end
    idle();
  endtask

  task automatic test_read_routing();
    do_reset();
    m1_read_req = 1'b1;
    @(negedge clk);
    checks++; if (m1_ready !== 1'b1 || s_read_req !== 1'b1) $display("FAIL rd_issue_m1 got ready=%b rreq=%b want 1 1", m1_ready, s_read_req); else passes++;
    step();
    m1_read_req = 1'b0; m0_read_req = 1'b1;
    s_read_data = 32'h3; s_read_data_valid = 1'b1;
    @(negedge clk);
    checks++; if (m0_ready !== 1'b1) $display("FAIL rd_issue_m0 got %b want 1", m0_ready); else passes++;
    checks++; if ({m1_read_data_valid, m0_read_data_valid} !== 2'b10) $display("FAIL rd_resp1_valid got %b want 10", {m1_read_data_valid, m0_read_data_valid}); else passes++;
    checks++; if (m1_read_data !== 32'h3) $display("FAIL rd_resp1_data got %h want 3", m1_read_data); else passes++;
    step();
    m0_read_req = 1'b0;
    s_read_data = 32'h6;
    @(negedge clk);
    checks++; if ({m1_read_data_valid, m0_read_data_valid} !== 2'b01) $display("FAIL rd_resp2_valid got %b want 01", {m1_read_data_valid, m0_read_data_valid}); else passes++;
    checks++; if (m0_read_data !== 32'h6) $display("FAIL rd_resp2_data got %h want 6", m0_read_data); else passes++;
    step();
    idle();
    checks++; if (dut.count !== 3'd0) $display("FAIL rd_count got %0d want 0", dut.count); else passes++;
  endtask

  task automatic test_fifo_full_wrap();
    bit head;
    do_reset();
    m0_read_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (m0_ready !== 1'b1) $display("FAIL full_fill cyc %0d got %b want 1", i, m0_ready); else passes++;
      step();
      exp_q.push_back(1'b0);
    end
    checks++; if (dut.count !== 3'd4) $display("FAIL full_count got %0d want 4", dut.count); else passes++;
    m1_write_req = 1'b1; m1_write_data = 32'h77;
    @(negedge clk);
    checks++; if ({m1_ready, m0_ready} !== 2'b10) $display("FAIL full_block got %b want 10", {m1_ready, m0_ready}); else passes++;
    checks++; if ({s_write_req, s_read_req} !== 2'b10) $display("FAIL full_s_req got %b want 10", {s_write_req, s_read_req}); else passes++;
    step();
    m1_write_req = 1'b0;
    s_read_data = 32'h100; s_read_data_valid = 1'b1;
    @(negedge clk);
    checks++; if (m0_ready !== 1'b0) $display("FAIL full_pop_block got %b want 0", m0_ready); else passes++;
    checks++; if (m0_read_data_valid !== 1'b1) $display("FAIL full_pop_valid got %b want 1", m0_read_data_valid); else passes++;
    step();
    void'(exp_q.pop_front());
    s_read_data_valid = 1'b0;
    @(negedge clk);
    checks++; if (m0_ready !== 1'b1) $display("FAIL full_after_pop got %b want 1", m0_ready); else passes++;
    step();
    exp_q.push_back(1'b0);
    m0_read_req = 1'b0; s_read_data_valid = 1'b1;
    step();
    void'(exp_q.pop_front());
    checks++; if (dut.count !== 3'd3) $display("FAIL full_drain_count got %0d want 3", dut.count); else passes++;
    // Ten overlapping push/pop cycles from alternating masters walk the pointers past the wrap point.
    for (int i = 0; i < 10; i++) begin
      m0_read_req = (i % 2 == 0); m1_read_req = (i % 2 == 1);
      s_read_data = 32'h200 + i; s_read_data_valid = 1'b1;
      head = exp_q[0];
      @(negedge clk);
      checks++; if ({m1_ready, m0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL wrap_grant cyc %0d got %b", i, {m1_ready, m0_ready}); else passes++;
      checks++; if ({m1_read_data_valid, m0_read_data_valid} !== (head ? 2'b10 : 2'b01)) $display("FAIL wrap_route cyc %0d got %b want head %0d", i, {m1_read_data_valid, m0_read_data_valid}, head); else passes++;
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(i % 2 == 1);
    end
    checks++; if (dut.count !== 3'd3) $display("FAIL wrap_count got %0d want 3", dut.count); else passes++;
    m0_read_req = 1'b0; m1_read_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      head = exp_q[0];
      @(negedge clk);
      checks++; if ({m1_read_data_valid, m0_read_data_valid} !== (head ? 2'b10 : 2'b01)) $display("FAIL drain_route %0d got %b want head %0d", i, {m1_read_data_valid, m0_read_data_valid}, head); else passes++;
      step();
      void'(exp_q.pop_front());
    end
    idle();
    checks++; if (dut.count !== 3'd0) $display("FAIL drain_count got %0d want 0", dut.count); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_read_req = 1'b1;
    step();
    m0_read_req = 1'b0; m1_read_req = 1'b1;
    step();
    idle();
    checks++; if (dut.count !== 3'd2) $display("FAIL mid_pre_count got %0d want 2", dut.count); else passes++;
    reset_n = 1'b0;
    #1;
    checks++; if (dut.count !== 3'd0) $display("FAIL mid_async_count got %0d want 0", dut.count); else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    s_read_data = 32'hDEAD; s_read_data_valid = 1'b1;
    @(negedge clk);
    checks++; if ({m1_read_data_valid, m0_read_data_valid} !== 2'b00) $display("FAIL mid_late_valid got %b want 00", {m1_read_data_valid, m0_read_data_valid}); else passes++;
    step();
    idle();
    checks++; if (dut.count !== 3'd0) $display("FAIL mid_post_count got %0d want 0", dut.count); else passes++;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_routing();
    test_fifo_full_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
